// File: rtl/monitor_contador.sv
// -----------------------------------------------------------------------------
// monitor_contador
// Watches an upstream N-bit counter and tallies its "zero-entry" events: edges
// where the counter value is 0 and the value seen on the previous edge was
// not. After a start request the block counts events until the tally reaches
// a target latched at start, then parks in FIN until cleared.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   rst        : asynchronous, active-low reset
//   contador   : value of the observed N-bit counter
//   iniciar    : start request (honoured only in IDLE)
//   borrar     : clear/abort request (wins over iniciar and over events)
//   meta       : target number of zero-entries, sampled only on start
//   vueltas    : registered tally of zero-entries since the last start
//   pulso_cero : registered one-cycle pulse per counted zero-entry
//   fin        : registered level, high while in FIN
//   estado     : state encoding IDLE=00, CUENTA=01, FIN=10 (11 unused)
// -----------------------------------------------------------------------------
module monitor_contador #(
  parameter int N = 2,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] contador,
  input  logic         iniciar,
  input  logic         borrar,
  input  logic [W-1:0] meta,
  output logic [W-1:0] vueltas,
  output logic         pulso_cero,
  output logic         fin,
  output logic [1:0]   estado
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CUENTA = 2'b01,
    FIN    = 2'b10
  } estado_e;

  estado_e        state_r;
  estado_e        state_next_s;
  logic [N-1:0]   prev_r;
  logic [W-1:0]   meta_r;
  logic [W-1:0]   meta_next_s;
  logic [W-1:0]   vueltas_r;
  logic [W-1:0]   vueltas_next_s;
  logic [W-1:0]   vueltas_inc_s;
  logic           pulso_r;
  logic           pulso_next_s;
  logic           fin_r;
  logic           evento_s;

  // Zero-entry detection: counter is at zero now but was not on the previous edge.
  always_comb begin
    evento_s      = (contador == {N{1'b0}}) && (prev_r != {N{1'b0}});
    vueltas_inc_s = vueltas_r + W'(1);
  end

  // Next-state, next-tally and pulse decode.
  always_comb begin
    state_next_s   = state_r;
    meta_next_s    = meta_r;
    vueltas_next_s = vueltas_r;
    pulso_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // borrar beats a simultaneous iniciar; events are not counted here,
        // which also keeps an event on the start edge out of the tally.
        if (borrar) begin
          state_next_s = IDLE;
        end else if (iniciar) begin
          state_next_s   = CUENTA;
          vueltas_next_s = {W{1'b0}};
          meta_next_s    = meta;
        end else begin
          state_next_s = IDLE;
        end
      end
      CUENTA: begin
        if (borrar) begin
          // Abort holds the tally and suppresses a coincident event.
          state_next_s = IDLE;
        end else if (meta_r == {W{1'b0}}) begin
          // A zero target is met immediately, without counting anything.
          state_next_s = FIN;
        end else if (evento_s) begin
          vueltas_next_s = vueltas_inc_s;
          pulso_next_s   = 1'b1;
          // Leaving at equality is what keeps the tally from wrapping.
          if (vueltas_inc_s == meta_r) begin
            state_next_s = FIN;
          end else begin
            state_next_s = CUENTA;
          end
        end else begin
          state_next_s = CUENTA;
        end
      end
      FIN: begin
        if (borrar) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FIN;
        end
      end
      default: begin
        // Unused encoding 11 falls back to IDLE.
        state_next_s = IDLE;
      end
    endcase
  end

  // State, tally, target and previous-sample registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      prev_r    <= {N{1'b0}};
      meta_r    <= {W{1'b0}};
      vueltas_r <= {W{1'b0}};
      pulso_r   <= 1'b0;
      fin_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      prev_r    <= contador;
      meta_r    <= meta_next_s;
      vueltas_r <= vueltas_next_s;
      pulso_r   <= pulso_next_s;
      fin_r     <= (state_next_s == FIN);
    end
  end

  assign vueltas    = vueltas_r;
  assign pulso_cero = pulso_r;
  assign fin        = fin_r;
  assign estado     = state_r;

  monitor_contador_chk #(
    .W (W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .vueltas    (vueltas_r),
    .meta_q     (meta_r),
    .pulso_cero (pulso_r),
    .fin        (fin_r),
    .estado     (state_r)
  );

endmodule

// -----------------------------------------------------------------------------
// monitor_contador_chk
// Invariants of monitor_contador: the tally never passes the latched target,
// fin mirrors the FIN state, pulso_cero stays low while in IDLE, and the
// unused state encoding is never held.
//
// Ports
//   clk, rst   : clock and active-low reset of the monitored block
//   vueltas    : tally register
//   meta_q     : latched target register
//   pulso_cero : pulse register
//   fin        : fin register
//   estado     : state register
// -----------------------------------------------------------------------------
module monitor_contador_chk #(
  parameter int W = 4
) (
  input logic         clk,
  input logic         rst,
  input logic [W-1:0] vueltas,
  input logic [W-1:0] meta_q,
  input logic         pulso_cero,
  input logic         fin,
  input logic [1:0]   estado
);

  a_no_overrun: assert property (@(posedge clk) disable iff (!rst)
    vueltas <= meta_q);

  a_fin_level: assert property (@(posedge clk) disable iff (!rst)
    fin == (estado == 2'b10));

  a_no_pulse_idle: assert property (@(posedge clk) disable iff (!rst)
    (estado == 2'b00) |-> !pulso_cero);

  a_state_legal: assert property (@(posedge clk) disable iff (!rst)
    estado != 2'b11);

endmodule

// File: tb/tb_monitor_contador.sv
// -----------------------------------------------------------------------------
// tb_monitor_contador
// Directed bench for monitor_contador (N=2, W=4). A table of per-cycle
// {inputs, expected outputs} rows covers the basic count, held zero, zero
// target, abort and start/clear conflicts; hand-written sequences cover the
// asynchronous reset and the full-scale target.
// -----------------------------------------------------------------------------
module tb_monitor_contador;

  localparam int N = 2;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] contador;
  logic         iniciar;
  logic         borrar;
  logic [W-1:0] meta;
  logic [W-1:0] vueltas;
  logic         pulso_cero;
  logic         fin;
  logic [1:0]   estado;

  monitor_contador #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .contador   (contador),
    .iniciar    (iniciar),
    .borrar     (borrar),
    .meta       (meta),
    .vueltas    (vueltas),
    .pulso_cero (pulso_cero),
    .fin        (fin),
    .estado     (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] c;
    logic         i;
    logic         b;
    logic [W-1:0] m;
    logic [W-1:0] ev;
    logic         ep;
    logic         ef;
    logic [1:0]   es;
  } vec_t;

  vec_t tbl [64];
  int   n_tbl = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic [N-1:0] c, input logic i, input logic b,
                     input logic [W-1:0] m, input logic [W-1:0] ev,
                     input logic ep, input logic ef, input logic [1:0] es);
    tbl[n_tbl].c  = c;
    tbl[n_tbl].i  = i;
    tbl[n_tbl].b  = b;
    tbl[n_tbl].m  = m;
    tbl[n_tbl].ev = ev;
    tbl[n_tbl].ep = ep;
    tbl[n_tbl].ef = ef;
    tbl[n_tbl].es = es;
    n_tbl++;
  endtask

  task automatic check(input string name, input logic [W-1:0] ev,
                       input logic ep, input logic ef, input logic [1:0] es);
    n_vec++;
    if ({vueltas, pulso_cero, fin, estado} !== {ev, ep, ef, es}) begin
      n_err++;
      $display("FAIL %s: got vueltas=%0d pulso=%b fin=%b estado=%b, want vueltas=%0d pulso=%b fin=%b estado=%b",
               name, vueltas, pulso_cero, fin, estado, ev, ep, ef, es);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic step(input logic [N-1:0] c, input logic i, input logic b,
                      input logic [W-1:0] m);
    contador = c;
    iniciar  = i;
    borrar   = b;
    meta     = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    contador = '0;
    iniciar  = 1'b0;
    borrar   = 1'b0;
    meta     = '0;
    #1 rst = 1'b0;
    #2;
    check("reset_state", 4'd0, 1'b0, 1'b0, 2'b00);
    #9 rst = 1'b1;  // release at t=12, between edges

    // Basic count: 3,2,1,0,3,2,1,0 with meta=2
    add(2'd3, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 2'b01);
    add(2'd2, 1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 2'b01);
    add(2'd1, 1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 2'b01);
    add(2'd0, 1'b0, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0, 2'b01);
    add(2'd3, 1'b0, 1'b0, 4'd2, 4'd1, 1'b0, 1'b0, 2'b01);
    add(2'd2, 1'b0, 1'b0, 4'd2, 4'd1, 1'b0, 1'b0, 2'b01);
    add(2'd1, 1'b0, 1'b0, 4'd2, 4'd1, 1'b0, 1'b0, 2'b01);
    add(2'd0, 1'b0, 1'b0, 4'd2, 4'd2, 1'b1, 1'b1, 2'b10);
    add(2'd0, 1'b0, 1'b0, 4'd2, 4'd2, 1'b0, 1'b1, 2'b10);
    // FIN ignores events and iniciar
    add(2'd1, 1'b0, 1'b0, 4'd2, 4'd2, 1'b0, 1'b1, 2'b10);
    add(2'd0, 1'b0, 1'b0, 4'd2, 4'd2, 1'b0, 1'b1, 2'b10);
    add(2'd0, 1'b1, 1'b0, 4'd5, 4'd2, 1'b0, 1'b1, 2'b10);
    // Clear from FIN holds vueltas; iniciar+borrar in IDLE stays IDLE
    add(2'd0, 1'b0, 1'b1, 4'd5, 4'd2, 1'b0, 1'b0, 2'b00);
    add(2'd0, 1'b1, 1'b1, 4'd5, 4'd2, 1'b0, 1'b0, 2'b00);
    add(2'd1, 1'b0, 1'b0, 4'd5, 4'd2, 1'b0, 1'b0, 2'b00);
    add(2'd0, 1'b0, 1'b0, 4'd5, 4'd2, 1'b0, 1'b0, 2'b00);
    // Held zero: 1,0,0,0,0 with meta=3, then iniciar ignored in CUENTA
    add(2'd1, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 2'b01);
    add(2'd0, 1'b0, 1'b0, 4'd3, 4'd1, 1'b1, 1'b0, 2'b01);
    add(2'd0, 1'b0, 1'b0, 4'd3, 4'd1, 1'b0, 1'b0, 2'b01);
    add(2'd0, 1'b0, 1'b0, 4'd3, 4'd1, 1'b0, 1'b0, 2'b01);
    add(2'd0, 1'b0, 1'b0, 4'd3, 4'd1, 1'b0, 1'b0, 2'b01);
    add(2'd0, 1'b1, 1'b0, 4'd9, 4'd1, 1'b0, 1'b0, 2'b01);
    // Abort on the same edge as a zero-entry, then restart with meta=1
    add(2'd2, 1'b0, 1'b0, 4'd9, 4'd1, 1'b0, 1'b0, 2'b01);
    add(2'd0, 1'b0, 1'b1, 4'd9, 4'd1, 1'b0, 1'b0, 2'b00);
    add(2'd3, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 2'b01);
    add(2'd0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1, 2'b10);
    add(2'd0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 2'b00);
    // Zero target: one cycle in CUENTA, then FIN with no pulse
    add(2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01);
    add(2'd1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 2'b10);
    add(2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 2'b10);
    // Event on the start edge is not counted
    add(2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);
    add(2'd2, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);
    add(2'd0, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 2'b01);
    add(2'd0, 1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 2'b01);

    for (int k = 0; k < n_tbl; k++) begin
      step(tbl[k].c, tbl[k].i, tbl[k].b, tbl[k].m);
      check($sformatf("row%0d", k), tbl[k].ev, tbl[k].ep, tbl[k].ef, tbl[k].es);
    end

    // Async reset while in CUENTA with vueltas=2
    step(2'd0, 1'b0, 1'b1, 4'd0);
    check("ar_clear", 4'd0, 1'b0, 1'b0, 2'b00);
    step(2'd3, 1'b1, 1'b0, 4'd3);
    check("ar_start", 4'd0, 1'b0, 1'b0, 2'b01);
    step(2'd0, 1'b0, 1'b0, 4'd3);
    check("ar_ev1", 4'd1, 1'b1, 1'b0, 2'b01);
    step(2'd1, 1'b0, 1'b0, 4'd3);
    check("ar_gap", 4'd1, 1'b0, 1'b0, 2'b01);
    step(2'd0, 1'b0, 1'b0, 4'd3);
    check("ar_ev2", 4'd2, 1'b1, 1'b0, 2'b01);
    #2 rst = 1'b0;
    #1;
    check("ar_async", 4'd0, 1'b0, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    check("ar_held", 4'd0, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;
    #1;
    check("ar_release", 4'd0, 1'b0, 1'b0, 2'b00);
    step(2'd1, 1'b0, 1'b0, 4'd3);
    check("ar_post1", 4'd0, 1'b0, 1'b0, 2'b00);
    step(2'd0, 1'b0, 1'b0, 4'd3);
    check("ar_post_ev", 4'd0, 1'b0, 1'b0, 2'b00);

    // Full-scale target: 15 zero-entries reach FIN without wrapping
    step(2'd1, 1'b1, 1'b0, 4'd15);
    check("max_start", 4'd0, 1'b0, 1'b0, 2'b01);
    for (int k = 1; k <= 15; k++) begin
      step(2'd0, 1'b0, 1'b0, 4'd15);
      check($sformatf("max_ev%0d", k), 4'(k), 1'b1, (k == 15),
            (k == 15) ? 2'b10 : 2'b01);
      step(2'd1, 1'b0, 1'b0, 4'd15);
      check($sformatf("max_gap%0d", k), 4'(k), 1'b0, (k == 15),
            (k == 15) ? 2'b10 : 2'b01);
    end
    step(2'd0, 1'b0, 1'b0, 4'd15);
    check("max_hold", 4'd15, 1'b0, 1'b1, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
